// File: rtl/uart_rx_to_axis.sv
// rtl/uart_rx_to_axis.sv - UART receiver delivering each word as one AXI-Stream beat (option: UART_RX_MAJORITY_EN)
module uart_rx_to_axis #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    rx,
  output logic [BIT_PER_WORD-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overrun_err
);

  localparam int CPP  = CLK_FREQ * 1_000_000 / BIT_RATE;
  localparam int HALF = CPP / 2;
  localparam int CW   = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int ADV  = 1;
`else
  localparam int ADV  = 0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta, rxs, rxs_prev;
  logic [2:0]              warm;
  logic [CW-1:0]           cnt_q, cnt_d, centre;
  logic [3:0]              bit_q, bit_d;
  logic [BIT_PER_WORD-1:0] shift_q, shift_d;
  logic                    perr_q, perr_d;
  logic                    deliver_q, deliver_d, ferr_d;
  logic                    at_adv, samp_bit;

  // warm fills after reset so the reset-forced 1s in the synchroniser never fake a falling edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      warm     <= 3'b000;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      warm     <= {warm[1:0], 1'b1};
    end
  end

  assign centre = (state_q == START) ? CW'(HALF - 1) : CW'(CPP - 1);
  assign at_adv = (cnt_q == centre + CW'(ADV));

`ifdef UART_RX_MAJORITY_EN
  logic s_m1, s_c;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_m1 <= 1'b1;
      s_c  <= 1'b1;
    end else begin
      if (cnt_q == centre - CW'(1)) s_m1 <= rxs;
      if (cnt_q == centre)          s_c  <= rxs;
    end
  end
  assign samp_bit = (s_m1 & s_c) | (s_m1 & rxs) | (s_c & rxs);
`else
  assign samp_bit = rxs;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (warm[2] && rxs_prev && !rxs) begin
          state_d = START;
          perr_d  = 1'b0;
        end
      end
      START: if (at_adv) begin
        // after an advance the counter is ADV cycles past centre, keeping later centres drift-free
        cnt_d   = CW'(ADV);
        state_d = samp_bit ? IDLE : DATA;
      end
      DATA: if (at_adv) begin
        cnt_d   = CW'(ADV);
        shift_d = {samp_bit, shift_q[BIT_PER_WORD-1:1]};
        bit_d   = bit_q + 4'd1;
        if (bit_q == 4'(BIT_PER_WORD - 1)) state_d = (PARITY_BIT != 0) ? PARITY : STOP1;
      end
      PARITY: if (at_adv) begin
        cnt_d   = CW'(ADV);
        perr_d  = (^shift_q) ^ samp_bit ^ (PARITY_BIT == 1);
        state_d = STOP1;
      end
      STOP1: if (at_adv) begin
        cnt_d = CW'(ADV);
        if (!samp_bit) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (STOP_BITS_NUM == 2) begin
          state_d = STOP2;
        end else begin
          deliver_d = 1'b1;
          state_d   = IDLE;
        end
      end
      STOP2: if (at_adv) begin
        cnt_d     = CW'(ADV);
        ferr_d    = !samp_bit;
        deliver_d = samp_bit;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      deliver_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      deliver_q <= deliver_d;
      frame_err <= ferr_d;
    end
  end

  // one-entry output register; a completed word is dropped only if the held beat is not leaving
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      parity_err    <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (deliver_q) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= shift_q;
          m_axis_tvalid <= 1'b1;
          parity_err    <= perr_q;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_to_axis.sv
// tb/tb_uart_rx_to_axis.sv - directed bench for uart_rx_to_axis: 8N1, 8E1, 8O1 and 8N2 receivers on separate lines
module tb_uart_rx_to_axis;

`ifdef UART_RX_MAJORITY_EN
  localparam int ADV = 1;
`else
  localparam int ADV = 0;
`endif

  logic       clk = 1'b0;
  logic       aresetn;
  logic [3:0] rx_v;
  logic [3:0] ready_v;
  logic [7:0] tdata [4];
  logic       tvalid [4];
  logic       perr [4];
  logic       ferr [4];
  logic       oerr [4];

  int beats [4] = '{default: 0};
  int pcnt  [4] = '{default: 0};
  int fcnt  [4] = '{default: 0};
  int ocnt  [4] = '{default: 0};
  logic [7:0] last [4] = '{default: 8'h00};

  int n_checks = 0;
  int n_errors = 0;
  int sb, sp, sf, so, lat;

  always #5 clk = ~clk;

  uart_rx_to_axis #(.CLK_FREQ(16), .BIT_RATE(1_000_000), .BIT_PER_WORD(8), .PARITY_BIT(0), .STOP_BITS_NUM(1)) u_n1 (
    .aclk(clk), .aresetn(aresetn), .rx(rx_v[0]), .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]),
    .m_axis_tready(ready_v[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(oerr[0]));
  uart_rx_to_axis #(.CLK_FREQ(16), .BIT_RATE(1_000_000), .BIT_PER_WORD(8), .PARITY_BIT(2), .STOP_BITS_NUM(1)) u_e1 (
    .aclk(clk), .aresetn(aresetn), .rx(rx_v[1]), .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]),
    .m_axis_tready(ready_v[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(oerr[1]));
  uart_rx_to_axis #(.CLK_FREQ(16), .BIT_RATE(1_000_000), .BIT_PER_WORD(8), .PARITY_BIT(1), .STOP_BITS_NUM(1)) u_o1 (
    .aclk(clk), .aresetn(aresetn), .rx(rx_v[2]), .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]),
    .m_axis_tready(ready_v[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(oerr[2]));
  uart_rx_to_axis #(.CLK_FREQ(16), .BIT_RATE(1_000_000), .BIT_PER_WORD(8), .PARITY_BIT(0), .STOP_BITS_NUM(2)) u_n2 (
    .aclk(clk), .aresetn(aresetn), .rx(rx_v[3]), .m_axis_tdata(tdata[3]), .m_axis_tvalid(tvalid[3]),
    .m_axis_tready(ready_v[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun_err(oerr[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tvalid[i] && ready_v[i]) begin
        beats[i]++;
        last[i] = tdata[i];
      end
      pcnt[i] += int'(perr[i]);
      fcnt[i] += int'(ferr[i]);
      ocnt[i] += int'(oerr[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic snap(input int ln);
    sb = beats[ln];
    sp = pcnt[ln];
    sf = fcnt[ln];
    so = ocnt[ln];
  endtask

  // bits[0] goes on the line first; each bit lasts 16 clocks; bit gbit gets a 1-clock inversion at its centre
  task automatic send_bits(input int ln, input logic [15:0] bits, input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 16; t++) begin
        rx_v[ln] = (i == gbit && t == 8) ? ~bits[i] : bits[i];
        tick();
      end
    end
    rx_v[ln] = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    rx_v    = 4'hF;
    ready_v = 4'hF;
    idle(3);
    check("rst_tvalid", {28'd0, tvalid[0], tvalid[1], tvalid[2], tvalid[3]}, 32'd0);
    check("rst_tdata", {24'd0, tdata[0]}, 32'h00);
    check("rst_err", {29'd0, perr[0], ferr[0], oerr[0]}, 32'd0);
    aresetn = 1'b1;
    idle(10);

    // 8N1 0xA5 with latency from start edge to tvalid
    snap(0);
    lat = 0;
    fork
      send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
      begin
        while (!tvalid[0] && lat < 400) begin
          tick();
          lat++;
        end
      end
    join
    idle(20);
    check("n1_latency", lat, 156 + ADV);
    check("n1_beats", beats[0] - sb, 1);
    check("n1_data", {24'd0, last[0]}, 32'hA5);
    check("n1_errs", (pcnt[0] - sp) + (fcnt[0] - sf) + (ocnt[0] - so), 0);

    // even parity: 0x03 needs parity 0
    snap(1);
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1);
    idle(20);
    check("e1_bad_beats", beats[1] - sb, 1);
    check("e1_bad_data", {24'd0, last[1]}, 32'h03);
    check("e1_bad_perr", pcnt[1] - sp, 1);
    snap(1);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1);
    idle(20);
    check("e1_ok_beats", beats[1] - sb, 1);
    check("e1_ok_perr", pcnt[1] - sp, 0);
    // odd parity: 0x03 needs parity 1
    snap(2);
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1);
    idle(20);
    check("o1_beats", beats[2] - sb, 1);
    check("o1_perr", pcnt[2] - sp, 0);

    // 8N2 with second stop low, then a clean frame
    snap(3);
    send_bits(3, {4'b0, 1'b0, 1'b1, 8'h5A, 1'b0}, 12, -1);
    idle(20);
    check("n2_ferr", fcnt[3] - sf, 1);
    check("n2_ferr_beats", beats[3] - sb, 0);
    snap(3);
    send_bits(3, {4'b0, 1'b1, 1'b1, 8'h11, 1'b0}, 12, -1);
    idle(20);
    check("n2_next_beats", beats[3] - sb, 1);
    check("n2_next_data", {24'd0, last[3]}, 32'h11);
    check("n2_next_errs", (pcnt[3] - sp) + (fcnt[3] - sf) + (ocnt[3] - so), 0);

    // overrun while the output register is held
    ready_v[0] = 1'b0;
    snap(0);
    send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);
    idle(5);
    send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1);
    idle(20);
    check("ovr_tvalid", {31'd0, tvalid[0]}, 1);
    check("ovr_tdata", {24'd0, tdata[0]}, 32'h11);
    check("ovr_pulse", ocnt[0] - so, 1);
    check("ovr_beats_held", beats[0] - sb, 0);
    ready_v[0] = 1'b1;
    idle(25);
    check("ovr_drain_beats", beats[0] - sb, 1);
    check("ovr_drain_data", {24'd0, last[0]}, 32'h11);
    check("ovr_drain_tvalid", {31'd0, tvalid[0]}, 0);

    // 4-cycle low glitch on an idle line
    snap(0);
    rx_v[0] = 1'b0;
    idle(4);
    rx_v[0] = 1'b1;
    idle(40);
    check("glitch_beats", beats[0] - sb, 0);
    check("glitch_errs", (pcnt[0] - sp) + (fcnt[0] - sf) + (ocnt[0] - so), 0);

`ifdef UART_RX_MAJORITY_EN
    snap(0);
    send_bits(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 4);
    idle(20);
    check("maj_beats", beats[0] - sb, 1);
    check("maj_data", {24'd0, last[0]}, 32'h00);
`endif

    // asynchronous reset in the middle of a frame while a beat is held
    ready_v[0] = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10, -1);
    idle(10);
    check("pre_rst_tvalid", {31'd0, tvalid[0]}, 1);
    snap(0);
    fork
      send_bits(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10, -1);
      begin
        idle(60);
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", {31'd0, tvalid[0]}, 0);
        check("arst_tdata", {24'd0, tdata[0]}, 32'h00);
        ready_v[0] = 1'b1;
        idle(71);
        aresetn = 1'b1;
      end
    join
    idle(30);
    check("post_rst_quiet", (beats[0] - sb) + (pcnt[0] - sp) + (fcnt[0] - sf) + (ocnt[0] - so), 0);
    snap(0);
    send_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, -1);
    idle(20);
    check("post_rst_beats", beats[0] - sb, 1);
    check("post_rst_data", {24'd0, last[0]}, 32'h81);
    check("post_rst_errs", (pcnt[0] - sp) + (fcnt[0] - sf) + (ocnt[0] - so), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
